// File: rtl/lvds_pkg.sv
// Shared types for the LVDS transmit/receive blocks.
package lvds_pkg;

  typedef struct packed {
    logic p;
    logic n;
  } pair_t;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } lvds_rx_state_e;

endpackage

// File: rtl/ELVDS_IBUF.sv
// Behavioural model of the emulated-LVDS differential input buffer primitive.
module ELVDS_IBUF (
  input  logic I,
  input  logic IB,
  output logic O
);

  assign O = I & ~IB;

endmodule

// File: rtl/TLVDS_IBUF.sv
// Behavioural model of the true-LVDS differential input buffer primitive.
module TLVDS_IBUF (
  input  logic I,
  input  logic IB,
  output logic O
);

  assign O = I & ~IB;

endmodule

// File: rtl/lvds_in.sv
// Differential pair to single-ended bit; picks the true or emulated input buffer.
module lvds_in
  import lvds_pkg::*;
#(
  parameter string Mode = "True"
) (
  input  pair_t pair,
  output logic  rx
);

  if (Mode == "True") begin : g_true
    TLVDS_IBUF u_ibuf (
      .I (pair.p),
      .IB(pair.n),
      .O (rx)
    );
  end else begin : g_emul
    ELVDS_IBUF u_ibuf (
      .I (pair.p),
      .IB(pair.n),
      .O (rx)
    );
  end

endmodule

// File: rtl/lvds_deser_rx.sv
// LVDS receiver: LSB-first deserialiser with sync-token word alignment and lock tracking.
module lvds_deser_rx
  import lvds_pkg::*;
#(
  parameter string             Mode      = "True",
  parameter int unsigned       Width     = 10,
  parameter logic [Width-1:0]  SyncWord  = 10'b1101010100,
  parameter int unsigned       LockCount = 4,
  parameter int unsigned       Timeout   = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  pair_t            pair,
  output logic [Width-1:0] word,
  output logic             valid,
  output logic             locked
);

  localparam int unsigned CntW = $clog2(Width);
  localparam int unsigned TW   = $clog2(Timeout + 1);
  localparam int unsigned HW   = $clog2(LockCount + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);
  localparam logic [TW-1:0]   TMax    = TW'(Timeout);
  localparam logic [HW-1:0]   LockMax = HW'(LockCount);

  logic rx_bit;

  lvds_in #(
    .Mode(Mode)
  ) u_in (
    .pair(pair),
    .rx  (rx_bit)
  );

  logic                rx_bit_q;
  // Bit 0 of the shift register is never read again, so only the upper bits are kept.
  logic [Width-1:1]    sr_q, sr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  lvds_rx_state_e      state_q, state_d;
  logic [HW-1:0]       hits_q, hits_d;
  logic [HW-1:0]       miss_q, miss_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [Width-1:0]    word_q, word_d;
  logic                valid_q, valid_d;

  logic [Width-1:0]    sr_next;
  logic                match;
  logic                boundary;
  logic [HW-1:0]       hits_inc;
  logic [HW-1:0]       miss_inc;
  logic [TW-1:0]       tcnt_inc;

  assign sr_next  = {rx_bit_q, sr_q};
  assign match    = (sr_next == SyncWord);
  assign boundary = (cnt_q == CntLast);
  assign hits_inc = (hits_q == LockMax) ? hits_q : hits_q + 1'b1;
  assign miss_inc = (miss_q == LockMax) ? miss_q : miss_q + 1'b1;
  assign tcnt_inc = (tcnt_q == TMax) ? tcnt_q : tcnt_q + 1'b1;

  always_comb begin
    sr_d    = sr_next[Width-1:1];
    cnt_d   = boundary ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    hits_d  = hits_q;
    miss_d  = miss_q;
    tcnt_d  = tcnt_q;
    word_d  = word_q;
    valid_d = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (match) begin
          // Re-phase the word counter so this bit closes a word.
          cnt_d   = '0;
          hits_d  = HW'(1);
          miss_d  = '0;
          tcnt_d  = '0;
          state_d = (LockCount <= 1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (match) begin
            hits_d = hits_inc;
            if (hits_inc == LockMax) begin
              state_d = LOCKED;
              miss_d  = '0;
              tcnt_d  = '0;
            end
          end else begin
            hits_d  = '0;
            state_d = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary && match) begin
          tcnt_d  = '0;
          miss_d  = '0;
          word_d  = sr_next;
          valid_d = 1'b1;
        end else if (boundary) begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TMax) begin
            state_d = HUNT;
          end else begin
            word_d  = sr_next;
            valid_d = 1'b1;
          end
        end else if (match) begin
          // A token off the word grid means the link has slipped.
          miss_d = miss_inc;
          if (miss_inc == LockMax) begin
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_bit_q <= 1'b0;
      sr_q     <= '0;
      cnt_q    <= '0;
      state_q  <= HUNT;
      hits_q   <= '0;
      miss_q   <= '0;
      tcnt_q   <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rx_bit_q <= rx_bit;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      hits_q   <= hits_d;
      miss_q   <= miss_d;
      tcnt_q   <= tcnt_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end

  assign word   = word_q;
  assign valid  = valid_q;
  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_lvds_deser_rx.sv
// Directed bench for lvds_deser_rx: word-level vector table plus reset and realignment sequences.
module tb_lvds_deser_rx;
  import lvds_pkg::*;

  localparam logic [9:0] Tok = 10'b1101010100;

  logic       clk = 1'b0;
  logic       rst_n;
  pair_t      pair;
  logic [9:0] word, word_e;
  logic       valid, valid_e;
  logic       locked, locked_e;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lvds_deser_rx #(
    .Mode     ("True"),
    .Width    (10),
    .SyncWord (Tok),
    .LockCount(4),
    .Timeout  (16)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pair  (pair),
    .word  (word),
    .valid (valid),
    .locked(locked)
  );

  lvds_deser_rx #(
    .Mode     ("Emulated"),
    .Width    (10),
    .SyncWord (Tok),
    .LockCount(4),
    .Timeout  (4096)
  ) u_dut_emu (
    .clk   (clk),
    .rst_n (rst_n),
    .pair  (pair),
    .word  (word_e),
    .valid (valid_e),
    .locked(locked_e)
  );

  // One received word; expectations hold one bit after the word's last bit is clocked.
  typedef struct {
    logic [9:0] data;
    int         pre;
    logic       exp_locked;
    logic       exp_valid;
    logic [9:0] exp_word;
    int         exp_stray;
  } vec_t;

  vec_t vecs[$];
  int   emu_last;

  function automatic void add(input logic [9:0] d, input int pre, input logic l, input logic v,
                              input logic [9:0] w, input int s);
    vec_t r;
    r.data       = d;
    r.pre        = pre;
    r.exp_locked = l;
    r.exp_valid  = v;
    r.exp_word   = w;
    r.exp_stray  = s;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    pair.p = b;
    pair.n = ~b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int k = 0; k < 10; k++) send_bit(w[k]);
  endtask

  task automatic check_vec(input int i, input int stray);
    check($sformatf("v%0d locked", i), 32'(locked), 32'(vecs[i].exp_locked));
    check($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].exp_valid));
    check($sformatf("v%0d word", i), 32'(word), 32'(vecs[i].exp_word));
    check($sformatf("v%0d stray_valid", i), 32'(stray), 32'(vecs[i].exp_stray));
    if (i <= emu_last) begin
      check($sformatf("v%0d emu_locked", i), 32'(locked_e), 32'(vecs[i].exp_locked));
      check($sformatf("v%0d emu_word", i), 32'(word_e), 32'(vecs[i].exp_word));
    end
  endtask

  initial begin
    int   stray;
    int   stray_prev;
    logic b;

    // Lock, then data words.
    for (int i = 0; i < 3; i++) add(Tok, 0, 1'b0, 1'b0, 10'h000, 0);
    add(Tok,     0, 1'b1, 1'b0, 10'h000, 0);
    add(10'h2AB, 0, 1'b1, 1'b1, 10'h2AB, 0);
    add(10'h155, 0, 1'b1, 1'b1, 10'h155, 0);
    add(Tok,     0, 1'b1, 1'b1, Tok,     0);
    // 15 non-token words then a token: lock held.
    for (int i = 0; i < 15; i++) add(10'h0F0, 0, 1'b1, 1'b1, 10'h0F0, 0);
    add(Tok, 0, 1'b1, 1'b1, Tok, 0);
    // 16 non-token words: lock lost on the 16th, word keeps its value.
    for (int i = 0; i < 15; i++) add(10'h0F0, 0, 1'b1, 1'b1, 10'h0F0, 0);
    emu_last = vecs.size() - 1;
    add(10'h30C, 0, 1'b0, 1'b0, 10'h0F0, 0);
    // Two tokens, a corrupted token, then four fresh tokens needed.
    add(Tok,     0, 1'b0, 1'b0, 10'h0F0, 0);
    add(Tok,     0, 1'b0, 1'b0, 10'h0F0, 0);
    add(10'h154, 0, 1'b0, 1'b0, 10'h0F0, 0);
    for (int i = 0; i < 3; i++) add(Tok, 0, 1'b0, 1'b0, 10'h0F0, 0);
    add(Tok,     0, 1'b1, 1'b0, 10'h0F0, 0);
    add(10'h2AB, 0, 1'b1, 1'b1, 10'h2AB, 0);
    // One-bit slip: boundary words are tokens shifted up by one with the previous bit below.
    add(Tok, 1, 1'b1, 1'b0, 10'h2A8, 1);
    add(Tok, 0, 1'b1, 1'b0, 10'h2A9, 1);
    add(Tok, 0, 1'b1, 1'b0, 10'h2A9, 1);
    add(Tok, 0, 1'b0, 1'b0, 10'h2A9, 1);
    for (int i = 0; i < 3; i++) add(Tok, 0, 1'b0, 1'b0, 10'h2A9, 0);
    add(Tok,     0, 1'b1, 1'b0, 10'h2A9, 0);
    add(10'h2AB, 0, 1'b1, 1'b1, 10'h2AB, 0);

    pair.p = 1'b0;
    pair.n = 1'b1;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset word", 32'(word), 32'h0);
    check("reset valid", 32'(valid), 32'h0);
    check("reset locked", 32'(locked), 32'h0);
    check("reset emu word", 32'(word_e), 32'h0);
    check("reset emu valid", 32'(valid_e), 32'h0);
    check("reset emu locked", 32'(locked_e), 32'h0);
    #2 rst_n = 1'b1;

    // Alternating bits never form the token.
    for (int i = 0; i < 200; i++) begin
      send_bit(1'(i % 2));
      check($sformatf("idle%0d locked_valid", i), 32'({locked, valid}), 32'h0);
    end

    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);

    stray_prev = 0;
    for (int r = 0; r < vecs.size(); r++) begin
      stray = 0;
      for (int k = 0; k < vecs[r].pre + 10; k++) begin
        b = (k < vecs[r].pre) ? 1'b0 : vecs[r].data[k - vecs[r].pre];
        send_bit(b);
        if (k == 0) begin
          if (r > 0) check_vec(r - 1, stray_prev);
        end else if (valid) begin
          stray++;
        end
      end
      stray_prev = stray;
    end
    send_bit(1'b0);
    check_vec(vecs.size() - 1, stray_prev);

    // Asynchronous reset one bit into a word while locked and strobing valid.
    #2 rst_n = 1'b0;
    #1;
    check("async word", 32'(word), 32'h0);
    check("async valid", 32'(valid), 32'h0);
    check("async locked", 32'(locked), 32'h0);
    check("async emu locked", 32'(locked_e), 32'h0);
    #1 rst_n = 1'b1;

    // Realignment after reset needs all four tokens.
    send_word(Tok);
    send_word(Tok);
    send_word(Tok);
    send_bit(Tok[0]);
    check("relock after 3 tokens", 32'(locked), 32'h0);
    for (int k = 1; k < 10; k++) send_bit(Tok[k]);
    send_bit(1'b0);
    check("relock after 4 tokens", 32'(locked), 32'h1);
    check("relock emu after 4 tokens", 32'(locked_e), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
